vram_read_arbiter: RTL and testbench
====================================

// Module: vram_read_arbiter
// PURPOSE
//  Shares one fixed-latency VRAM read port between REQUESTERS clients (sprite, tilemap, CPU readback...).
//  Round-robin grant, at most one read issued per cycle. A one-hot grant tag travels through an
//  internal LATENCY-deep delay line, so each returning word reaches only the client that requested it.
//  Sits between the VDP fetch units and the VRAM read port.
// PARAMETERS
//  REQUESTERS  4   number of clients (2..8)
//  ADDR_WIDTH  14  VRAM word address width
//  DATA_WIDTH  16  VRAM word width
//  LATENCY     2   cycles from mem_read high to mem_data valid (>=1)
// PORTS
//  clk          in   1                      system clock
//  reset        in   1                      synchronous, active-high reset
//  req          in   REQUESTERS             per-client read request, level
//  addr         in   REQUESTERS*ADDR_WIDTH  per-client address, client i at [i*AW +: AW]
//  ack          out  REQUESTERS             one-hot, combinational: request accepted this cycle
//  mem_read     out  1                      registered read strobe to VRAM
//  mem_addr     out  ADDR_WIDTH             registered read address
//  mem_data     in   DATA_WIDTH             VRAM data, valid LATENCY cycles after mem_read
//  rd_data      out  DATA_WIDTH             registered returned word, shared by all clients
//  rd_valid     out  REQUESTERS             one-hot registered: rd_data belongs to client i
//  stall_count  out  16                     stall statistic (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: mem_read=0, mem_addr=0, rd_data=0, rd_valid=0, stall_count=0,
//    all tag stages cleared, rr pointer last=REQUESTERS-1, so client 0 wins first.
//  - Arbitration (combinational): search starts at index last+1 mod REQUESTERS and grants the first
//    client with req=1. ack=grant. On a grant, last<=granted index at the clock edge; otherwise last holds.
//  - Handshake: client holds req and addr stable until it sees ack=1 in the same cycle.
//    req still high on the next cycle is a new request. Back-to-back grants to different clients every cycle.
//  - Issue: a grant in cycle T gives mem_read=1 and mem_addr=addr[granted] in cycle T+1.
//    mem_read=0 when nothing is granted.
//  - Tag delay: the grant vector is registered with mem_read, then delayed LATENCY more stages.
//    In cycle T+1+LATENCY: rd_data<=mem_data, rd_valid<=tag. rd_valid pulses in cycle T+2+LATENCY.
//    Total latency from ack to rd_valid = LATENCY+2. When the tag is zero, rd_data holds its value.
//  - Pipelined: up to LATENCY+1 reads in flight; no backpressure. Clients must accept rd_valid when it arrives.
//  - Single requester: re-granted every cycle when req is held. No starvation:
//    worst-case wait = REQUESTERS-1 grants.
//  - Reset mid-operation: all in-flight tags are dropped. No rd_valid for any read issued before reset.
//    mem_data arriving afterwards is ignored.
//  - ack, rd_valid and the tags are never multi-hot. X on addr of non-granted clients has no effect.
// CONFIGURATION
//  - VRAM_ARB_STALL_COUNT_EN defined:
//    - stall_count increments in each cycle where some req=1 client does not get ack.
//    - Saturates at 16'hFFFF and clears on reset.
//  - Not defined: stall_count is tied to 16'h0000 and no counter logic is built. The port is always present.
// TESTING (REQUESTERS=4, LATENCY=2, mem model returns {2'b0,addr} after 2 cycles)
//  1. Single client: req[2]=1, addr2=14'h0123 in cycle 0.
//     -> ack=4'b0100 cycle 0; mem_read/mem_addr=0123 cycle 1; rd_valid=4'b0100, rd_data=16'h0123 cycle 4.
//  2. All four req held high from reset.
//     -> ack sequence 0001,0010,0100,1000,0001; rd_valid follows the same order 4 cycles later, no gaps.
//  3. req[1] and req[3] only, held high.
//     -> acks alternate 0010,1000,0010...; stall_count +1 per cycle with macro, stays 0 without it.
//  4. reset pulsed 1 cycle after 3 back-to-back grants.
//     -> no rd_valid afterwards; next grant starts at client 0.
//  5. Macro on, req[0]=req[1]=1 held for 70000 cycles.
//     -> stall_count saturates at 16'hFFFF, no wrap.
//  6. LATENCY=1 build, client 0 request.
//     -> rd_valid 3 cycles after ack with correct data.

Source files
------------

// File: rtl/vram_read_arbiter.sv
// rtl/vram_read_arbiter.sv - round-robin arbiter sharing one fixed-latency VRAM read port
//
// Purpose:
//   Several VDP fetch clients share one VRAM read port. A round-robin arbiter
//   grants at most one client per cycle and registers that client's address onto
//   the read port. A one-hot grant tag travels down a LATENCY-deep delay line
//   alongside the read, so each returning word is flagged only for its requester.
//
// Parameters:
//   REQUESTERS  number of clients (2..8)
//   ADDR_WIDTH  VRAM word address width
//   DATA_WIDTH  VRAM word width
//   LATENCY     cycles from o_mem_read high to i_mem_data valid (>=1)
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous, active-high reset
//   i_req          per-client read request (level, held until acked)
//   i_addr         per-client address, client i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   o_ack          one-hot, combinational: request accepted this cycle
//   o_mem_read     registered read strobe to VRAM
//   o_mem_addr     registered read address
//   i_mem_data     VRAM data, valid LATENCY cycles after o_mem_read
//   o_rd_data      registered returned word, shared by all clients
//   o_rd_valid     one-hot registered: o_rd_data belongs to client i
//   o_stall_count  cycles in which a requesting client was not acked
//
// Build option:
//   VRAM_ARB_STALL_COUNT_EN  when defined, builds the saturating 16-bit stall
//                            counter; otherwise o_stall_count is tied to zero.

module vram_read_arbiter #(
    parameter int REQUESTERS = 4,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [REQUESTERS-1:0]            i_req,
    input  logic [REQUESTERS*ADDR_WIDTH-1:0] i_addr,
    output logic [REQUESTERS-1:0]            o_ack,
    output logic                             o_mem_read,
    output logic [ADDR_WIDTH-1:0]            o_mem_addr,
    input  logic [DATA_WIDTH-1:0]            i_mem_data,
    output logic [DATA_WIDTH-1:0]            o_rd_data,
    output logic [REQUESTERS-1:0]            o_rd_valid,
    output logic [15:0]                      o_stall_count
);

    localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    // Index of the most recently granted client; search starts one past it.
    logic [IDX_W-1:0]      r_last;

    logic [REQUESTERS-1:0] w_grant;
    logic [IDX_W-1:0]      w_grant_idx;
    logic                  w_found;

    logic                  r_mem_read;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [REQUESTERS-1:0] r_rd_valid;

    // r_tag[0] is aligned with o_mem_read; r_tag[LATENCY] is aligned with the
    // cycle in which the corresponding word is present on i_mem_data.
    logic [REQUESTERS-1:0] r_tag [0:LATENCY];

    // Round-robin search: visit last+1, last+2, ... wrapping, first requester wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_grant     = '0;
        for (int k = 1; k <= REQUESTERS; k++) begin
            int v_idx;
            v_idx = (int'(r_last) + k) % REQUESTERS;
            if (!w_found && i_req[v_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = v_idx[IDX_W-1:0];
            end
        end
        if (w_found) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign o_ack = w_grant;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last     <= IDX_W'(REQUESTERS - 1);
            r_mem_read <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_mem_read <= w_found;
            if (w_found) begin
                r_last     <= w_grant_idx;
                r_mem_addr <= i_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    // Tag delay line; clearing it on reset drops every read still in flight,
    // so late VRAM data can never produce an o_rd_valid.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int s = 0; s <= LATENCY; s++) begin
                r_tag[s] <= '0;
            end
        end else begin
            r_tag[0] <= w_grant;
            for (int s = 1; s <= LATENCY; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
        end
    end

    // Capture returning word only when a tag accompanies it; otherwise hold.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= r_tag[LATENCY];
            if (|r_tag[LATENCY]) begin
                r_rd_data <= i_mem_data;
            end
        end
    end

    assign o_mem_read = r_mem_read;
    assign o_mem_addr = r_mem_addr;
    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;

`ifdef VRAM_ARB_STALL_COUNT_EN
    logic [15:0] r_stall_count;
    logic        w_stall;

    // Only one client can be acked, so any other active request is a stall.
    assign w_stall = |(i_req & ~w_grant);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_count <= 16'h0000;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'h0001;
        end
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_vram_read_arbiter.sv
// tb/tb_vram_read_arbiter.sv - directed vector bench for vram_read_arbiter

module tb_vram_read_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [55:0] addr;
    logic [3:0]  ack;
    logic        mem_read;
    logic [13:0] mem_addr;
    logic [15:0] mem_data;
    logic [15:0] rd_data;
    logic [3:0]  rd_valid;
    logic [15:0] stall_count;

    logic [3:0]  l1_req;
    logic [55:0] l1_addr;
    logic [3:0]  l1_ack;
    logic        l1_mem_read;
    logic [13:0] l1_mem_addr;
    logic [15:0] l1_mem_data;
    logic [15:0] l1_rd_data;
    logic [3:0]  l1_rd_valid;
    logic [15:0] l1_stall_count;

    int n_vec;
    int n_fail;

    vram_read_arbiter #(
        .REQUESTERS(4), .ADDR_WIDTH(14), .DATA_WIDTH(16), .LATENCY(2)
    ) u_dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_addr(addr),
        .o_ack(ack), .o_mem_read(mem_read), .o_mem_addr(mem_addr),
        .i_mem_data(mem_data), .o_rd_data(rd_data), .o_rd_valid(rd_valid),
        .o_stall_count(stall_count)
    );

    vram_read_arbiter #(
        .REQUESTERS(4), .ADDR_WIDTH(14), .DATA_WIDTH(16), .LATENCY(1)
    ) u_dut_l1 (
        .i_clk(clk), .i_reset(reset), .i_req(l1_req), .i_addr(l1_addr),
        .o_ack(l1_ack), .o_mem_read(l1_mem_read), .o_mem_addr(l1_mem_addr),
        .i_mem_data(l1_mem_data), .o_rd_data(l1_rd_data), .o_rd_valid(l1_rd_valid),
        .o_stall_count(l1_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM models: data = {2'b0, address} LATENCY cycles after the address is presented.
    logic [13:0] m_d1, m_d2, l1_d1;
    always_ff @(posedge clk) begin
        m_d1  <= mem_addr;
        m_d2  <= m_d1;
        l1_d1 <= l1_mem_addr;
    end
    assign mem_data    = {2'b00, m_d2};
    assign l1_mem_data = {2'b00, l1_d1};

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [3:0]  ack;
        logic        mr;
        logic [13:0] ma;
        logic [3:0]  rv;
        logic [15:0] rd;
        logic [15:0] st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [3:0] q, logic [3:0] a, logic m,
                                logic [13:0] ma, logic [3:0] v, logic [15:0] d,
                                logic [15:0] s);
        vec_t t;
        t.rst = r; t.req = q; t.ack = a; t.mr = m; t.ma = ma; t.rv = v; t.rd = d; t.st = s;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] st_exp(logic [15:0] s);
`ifdef VRAM_ARB_STALL_COUNT_EN
        return s;
`else
        return 16'h0000 & s;
`endif
    endfunction

    initial begin
        n_vec  = 0;
        n_fail = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        // client 3..0 addresses
        addr   = {14'h0033, 14'h0123, 14'h0021, 14'h0010};
        l1_req = 4'b0000;
        l1_addr = {14'bx, 14'bx, 14'h1555, 14'h2ABC};

        //             rst  req      ack      mr  ma        rv       rd        st
        // single client 2
        tbl.push_back(mk(0, 4'b0100, 4'b0100, 0, 14'h0000, 4'b0000, 16'h0000, 0));  // c0
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 14'h0123, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0100, 16'h0123, 0));  // c4
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0123, 0));
        // reset, then all four held
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0123, 0));  // c6
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0010, 1, 14'h0010, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b1111, 4'b0100, 1, 14'h0021, 4'b0000, 16'h0000, 2));
        tbl.push_back(mk(0, 4'b1111, 4'b1000, 1, 14'h0123, 4'b0000, 16'h0000, 3));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 1, 14'h0033, 4'b0001, 16'h0010, 4));  // c11
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 14'h0010, 4'b0010, 16'h0021, 5));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0100, 16'h0123, 5));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b1000, 16'h0033, 5));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0001, 16'h0010, 5));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0010, 5));  // c16
        // clients 1 and 3 only
        tbl.push_back(mk(0, 4'b1010, 4'b0010, 0, 14'h0000, 4'b0000, 16'h0010, 5));
        tbl.push_back(mk(0, 4'b1010, 4'b1000, 1, 14'h0021, 4'b0000, 16'h0010, 6));
        tbl.push_back(mk(0, 4'b1010, 4'b0010, 1, 14'h0033, 4'b0000, 16'h0010, 7));
        tbl.push_back(mk(0, 4'b1010, 4'b1000, 1, 14'h0021, 4'b0000, 16'h0010, 8));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 14'h0033, 4'b0010, 16'h0021, 9));  // c21
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b1000, 16'h0033, 9));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0010, 16'h0021, 9));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b1000, 16'h0033, 9));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0033, 9));
        // three back-to-back grants, then reset drops them
        tbl.push_back(mk(0, 4'b0111, 4'b0001, 0, 14'h0000, 4'b0000, 16'h0033, 9));  // c26
        tbl.push_back(mk(0, 4'b0111, 4'b0010, 1, 14'h0010, 4'b0000, 16'h0033, 10));
        tbl.push_back(mk(0, 4'b0111, 4'b0100, 1, 14'h0021, 4'b0000, 16'h0033, 11));
        tbl.push_back(mk(1, 4'b0000, 4'b0000, 1, 14'h0123, 4'b0000, 16'h0033, 12)); // c29
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 0));
        tbl.push_back(mk(0, 4'b1111, 4'b0001, 0, 14'h0000, 4'b0000, 16'h0000, 0));  // c33
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 1, 14'h0010, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0000, 16'h0000, 1));
        tbl.push_back(mk(0, 4'b0000, 4'b0000, 0, 14'h0000, 4'b0001, 16'h0010, 1));  // c37

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", 32'(ack), 32'h0);
        check("reset mem_read", 32'(mem_read), 32'h0);
        check("reset mem_addr", 32'(mem_addr), 32'h0);
        check("reset rd_valid", 32'(rd_valid), 32'h0);
        check("reset rd_data", 32'(rd_data), 32'h0);
        check("reset stall_count", 32'(stall_count), 32'h0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset = tbl[i].rst;
            req   = tbl[i].req;
            @(negedge clk);
            check($sformatf("v%0d ack", i), 32'(ack), 32'(tbl[i].ack));
            check($sformatf("v%0d mem_read", i), 32'(mem_read), 32'(tbl[i].mr));
            if (tbl[i].mr) begin
                check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].ma));
            end
            check($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
            check($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(tbl[i].rd));
            check($sformatf("v%0d stall_count", i), 32'(stall_count), 32'(st_exp(tbl[i].st)));
        end

        // LATENCY=1 instance: client 0, rd_valid three cycles after ack
        @(posedge clk);
        #1;
        req    = 4'b0000;
        l1_req = 4'b0001;
        @(negedge clk);
        check("l1 ack", 32'(l1_ack), 32'h1);
        @(posedge clk);
        #1;
        l1_req = 4'b0000;
        @(negedge clk);
        check("l1 mem_read", 32'(l1_mem_read), 32'h1);
        check("l1 mem_addr", 32'(l1_mem_addr), 32'h2ABC);
        @(negedge clk);
        check("l1 rd_valid early", 32'(l1_rd_valid), 32'h0);
        @(negedge clk);
        check("l1 rd_valid", 32'(l1_rd_valid), 32'h1);
        check("l1 rd_data", 32'(l1_rd_data), 32'h2ABC);
        @(negedge clk);
        check("l1 rd_valid after", 32'(l1_rd_valid), 32'h0);

`ifdef VRAM_ARB_STALL_COUNT_EN
        // stall counter saturation with two clients contending
        @(posedge clk);
        #1;
        reset = 1'b1;
        req   = 4'b0000;
        @(posedge clk);
        #1;
        reset = 1'b0;
        req   = 4'b0011;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        check("stall count 1000", 32'(stall_count), 32'd1000);
        repeat (69000) @(posedge clk);
        @(negedge clk);
        check("stall saturated", 32'(stall_count), 32'hFFFF);
        req = 4'b0000;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
